// File: rtl/reorder_buffer_if.sv
// Dispatcher/execution/commit bundle between the out-of-order core and the reorder buffer.
// The master side drives allocation, queries and writebacks; the slave (ROB) drives status and commit outputs.
interface reorder_buffer_if;
  // Allocation from the dispatcher
  logic        en_signal_from_dispatcher;
  logic [4:0]  rd_from_dispatcher;
  logic        is_jump_from_dispatcher;
  logic        is_store_from_dispatcher;
  logic        predicted_jump_from_dispatcher;
  logic [31:0] pc_from_dispatcher;
  logic [31:0] rollback_pc_from_dispatcher;
  logic [4:0]  alloc_id_out;
  logic        full_to_fetcher;

  // Operand queries
  logic [4:0]  Q1_from_dispatcher;
  logic [4:0]  Q2_from_dispatcher;
  logic        Q1_ready_to_dispatcher;
  logic        Q2_ready_to_dispatcher;
  logic [31:0] data1_to_dispatcher;
  logic [31:0] data2_to_dispatcher;

  // Writebacks
  logic        valid_from_alu;
  logic [4:0]  rob_id_from_alu;
  logic [31:0] result_from_alu;
  logic        jump_from_alu;
  logic        valid_from_lsu;
  logic [4:0]  rob_id_from_lsu;
  logic [31:0] result_from_lsu;

  // Commit, predictor update and rollback
  logic        commit_en_to_reg;
  logic [4:0]  commit_rd_to_reg;
  logic [31:0] commit_data_to_reg;
  logic [4:0]  commit_id_to_reg;
  logic        commit_store_to_lsb;
  logic [4:0]  commit_id_to_lsb;
  logic        bp_update_en;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        rollback_flag_to_all;
  logic [31:0] rollback_pc_to_fetcher;

  modport master (
    output en_signal_from_dispatcher, rd_from_dispatcher, is_jump_from_dispatcher,
           is_store_from_dispatcher, predicted_jump_from_dispatcher, pc_from_dispatcher,
           rollback_pc_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
           valid_from_alu, rob_id_from_alu, result_from_alu, jump_from_alu,
           valid_from_lsu, rob_id_from_lsu, result_from_lsu,
    input  alloc_id_out, full_to_fetcher, Q1_ready_to_dispatcher, Q2_ready_to_dispatcher,
           data1_to_dispatcher, data2_to_dispatcher, commit_en_to_reg, commit_rd_to_reg,
           commit_data_to_reg, commit_id_to_reg, commit_store_to_lsb, commit_id_to_lsb,
           bp_update_en, bp_pc, bp_taken, rollback_flag_to_all, rollback_pc_to_fetcher
  );

  modport slave (
    input  en_signal_from_dispatcher, rd_from_dispatcher, is_jump_from_dispatcher,
           is_store_from_dispatcher, predicted_jump_from_dispatcher, pc_from_dispatcher,
           rollback_pc_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
           valid_from_alu, rob_id_from_alu, result_from_alu, jump_from_alu,
           valid_from_lsu, rob_id_from_lsu, result_from_lsu,
    output alloc_id_out, full_to_fetcher, Q1_ready_to_dispatcher, Q2_ready_to_dispatcher,
           data1_to_dispatcher, data2_to_dispatcher, commit_en_to_reg, commit_rd_to_reg,
           commit_data_to_reg, commit_id_to_reg, commit_store_to_lsb, commit_id_to_lsb,
           bp_update_en, bp_pc, bp_taken, rollback_flag_to_all, rollback_pc_to_fetcher
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates in dispatch order, captures ALU/LSU results,
// commits the head in program order and raises a one-cycle rollback on a mispredicted jump.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = 5;
  localparam int unsigned XW = 32;

  typedef struct packed {
    logic          busy;
    logic          ready;
    logic [IW-1:0] rd;
    logic          is_jump;
    logic          is_store;
    logic          pred;
    logic          actual;
    logic [XW-1:0] pc;
    logic [XW-1:0] rollback_pc;
    logic [XW-1:0] value;
  } entry_t;

  entry_t        rob_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          rollback_q;

  logic          commit_en_q;
  logic [IW-1:0] commit_rd_q;
  logic [XW-1:0] commit_data_q;
  logic [IW-1:0] commit_id_q;
  logic          commit_store_q;
  logic [IW-1:0] commit_lsb_id_q;
  logic          bp_en_q;
  logic [XW-1:0] bp_pc_q;
  logic          bp_taken_q;
  logic [XW-1:0] rollback_pc_q;

  entry_t        head_e;
  entry_t        new_entry;
  logic          commit_fire;
  logic          mispredict;
  logic          alloc_fire;
  logic          alu_hit;
  logic          lsu_hit;
  logic [PW-1:0] alu_idx;
  logic [PW-1:0] lsu_idx;
  logic [PW-1:0] q1_idx;
  logic [PW-1:0] q2_idx;
  logic [IW-1:0] head_id;

  // ID 0 means "no entry"; IDs above DEPTH never name a slot
  function automatic logic id_valid(input logic [IW-1:0] id);
    return (id != '0) && (32'(id) <= DEPTH);
  endfunction

  function automatic logic [PW-1:0] to_idx(input logic [IW-1:0] id);
    return PW'(id - IW'(1));
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign head_e  = rob_q[head_q];
  assign head_id = IW'(head_q) + IW'(1);

  // Commit and flush decisions use registered state only, so a same-cycle
  // writeback to the head is committed one cycle later.
  always_comb begin
    commit_fire = rdy_in && head_e.busy && head_e.ready;
    mispredict  = commit_fire && head_e.is_jump && (head_e.actual != head_e.pred);
    alloc_fire  = rdy_in && bus.en_signal_from_dispatcher && !mispredict && !rollback_q &&
                  (32'(count_q) < DEPTH);
  end

  always_comb begin
    alu_idx = to_idx(bus.rob_id_from_alu);
    lsu_idx = to_idx(bus.rob_id_from_lsu);
    alu_hit = bus.valid_from_alu && id_valid(bus.rob_id_from_alu) && rob_q[alu_idx].busy;
    lsu_hit = bus.valid_from_lsu && id_valid(bus.rob_id_from_lsu) && rob_q[lsu_idx].busy;
  end

  always_comb begin
    new_entry             = '0;
    new_entry.busy        = 1'b1;
    new_entry.rd          = bus.rd_from_dispatcher;
    new_entry.is_jump     = bus.is_jump_from_dispatcher;
    new_entry.is_store    = bus.is_store_from_dispatcher;
    new_entry.pred        = bus.predicted_jump_from_dispatcher;
    new_entry.pc          = bus.pc_from_dispatcher;
    new_entry.rollback_pc = bus.rollback_pc_from_dispatcher;
  end

  always_comb begin
    count_next = count_q;
    case ({alloc_fire, commit_fire})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Operand queries see only registered entry state
  always_comb begin
    q1_idx = to_idx(bus.Q1_from_dispatcher);
    q2_idx = to_idx(bus.Q2_from_dispatcher);
    bus.Q1_ready_to_dispatcher = 1'b0;
    bus.Q2_ready_to_dispatcher = 1'b0;
    bus.data1_to_dispatcher    = '0;
    bus.data2_to_dispatcher    = '0;
    if (id_valid(bus.Q1_from_dispatcher)) begin
      bus.Q1_ready_to_dispatcher = rob_q[q1_idx].busy && rob_q[q1_idx].ready;
      bus.data1_to_dispatcher    = rob_q[q1_idx].value;
    end
    if (id_valid(bus.Q2_from_dispatcher)) begin
      bus.Q2_ready_to_dispatcher = rob_q[q2_idx].busy && rob_q[q2_idx].ready;
      bus.data2_to_dispatcher    = rob_q[q2_idx].value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) rob_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      rollback_q      <= 1'b0;
      commit_en_q     <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
      commit_id_q     <= '0;
      commit_store_q  <= 1'b0;
      commit_lsb_id_q <= '0;
      bp_en_q         <= 1'b0;
      bp_pc_q         <= '0;
      bp_taken_q      <= 1'b0;
      rollback_pc_q   <= '0;
    end else if (!rdy_in) begin
      commit_en_q    <= 1'b0;
      commit_store_q <= 1'b0;
      bp_en_q        <= 1'b0;
      rollback_q     <= 1'b0;
    end else begin
      commit_en_q    <= 1'b0;
      commit_store_q <= 1'b0;
      bp_en_q        <= 1'b0;
      rollback_q     <= 1'b0;

      if (alloc_fire) begin
        rob_q[tail_q] <= new_entry;
        tail_q        <= wrap_inc(tail_q);
      end

      if (alu_hit) begin
        rob_q[alu_idx].ready  <= 1'b1;
        rob_q[alu_idx].value  <= bus.result_from_alu;
        rob_q[alu_idx].actual <= bus.jump_from_alu;
      end
      if (lsu_hit) begin
        rob_q[lsu_idx].ready <= 1'b1;
        rob_q[lsu_idx].value <= bus.result_from_lsu;
      end

      if (commit_fire) begin
        rob_q[head_q].busy <= 1'b0;
        head_q             <= wrap_inc(head_q);
        if (head_e.is_store) begin
          commit_store_q  <= 1'b1;
          commit_lsb_id_q <= head_id;
        end else if (head_e.rd != '0) begin
          commit_en_q   <= 1'b1;
          commit_rd_q   <= head_e.rd;
          commit_data_q <= head_e.value;
          commit_id_q   <= head_id;
        end
        if (head_e.is_jump) begin
          bp_en_q    <= 1'b1;
          bp_pc_q    <= head_e.pc;
          bp_taken_q <= head_e.actual;
        end
      end

      // Wrong-path flush overrides every other pointer and busy update
      if (mispredict) begin
        for (int i = 0; i < int'(DEPTH); i++) rob_q[i].busy <= 1'b0;
        head_q        <= '0;
        tail_q        <= '0;
        count_q       <= '0;
        rollback_q    <= 1'b1;
        rollback_pc_q <= head_e.rollback_pc;
      end else begin
        count_q <= count_next;
      end
    end
  end

  assign bus.alloc_id_out    = IW'(tail_q) + IW'(1);
  assign bus.full_to_fetcher = (32'(count_q) >= DEPTH - 2);

  // Pulses are masked while stalled; held fields keep their last values
  assign bus.commit_en_to_reg       = commit_en_q && rdy_in;
  assign bus.commit_rd_to_reg       = commit_rd_q;
  assign bus.commit_data_to_reg     = commit_data_q;
  assign bus.commit_id_to_reg       = commit_id_q;
  assign bus.commit_store_to_lsb    = commit_store_q && rdy_in;
  assign bus.commit_id_to_lsb       = commit_lsb_id_q;
  assign bus.bp_update_en           = bp_en_q && rdy_in;
  assign bus.bp_pc                  = bp_pc_q;
  assign bus.bp_taken               = bp_taken_q;
  assign bus.rollback_flag_to_all   = rollback_q && rdy_in;
  assign bus.rollback_pc_to_fetcher = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand sequences for corner cases,
// and random traffic checked every cycle against a queue-based program-order model.
module tb_reorder_buffer;
  localparam int unsigned DEPTH = 16;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   n_pass;
  int   n_total;

  always #5 clk_in = ~clk_in;

  reorder_buffer_if bus ();

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  typedef struct {
    logic        rdy, en;
    logic [4:0]  rd;
    logic        jmp, st, pred;
    logic [31:0] pc, rbpc;
    logic [4:0]  q1, q2;
    logic        av;
    logic [4:0]  aid;
    logic [31:0] ares;
    logic        aj;
    logic        lv;
    logic [4:0]  lid;
    logic [31:0] lres;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          exp_alloc;
    logic        exp_cen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    int          id;
    bit          ready;
    logic [4:0]  rd;
    bit          jmp, st, pred, act;
    logic [31:0] pc, rbpc, val;
  } ment_t;

  // Reference model: program-order queue of live instructions plus expected outputs
  ment_t       mq[$];
  int          m_next;
  bit          m_rb;
  logic        e_cen, e_cst, e_bpen, e_bpt, e_rb;
  logic [4:0]  e_crd, e_cid, e_stid;
  logic [31:0] e_cdata, e_bppc, e_rbpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t mk_en(input int rd);
    stim_t s;
    s = idle();
    s.en = 1'b1;
    s.rd = 5'(rd);
    s.pc = 32'(rd * 4);
    return s;
  endfunction

  function automatic stim_t mk_wb(input int id, input logic [31:0] v);
    stim_t s;
    s = idle();
    s.av = 1'b1;
    s.aid = 5'(id);
    s.ares = v;
    return s;
  endfunction

  function automatic int m_find(input int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_next = 1;
    m_rb = 1'b0;
    {e_cen, e_cst, e_bpen, e_bpt, e_rb} = '0;
    {e_crd, e_cid, e_stid} = '0;
    {e_cdata, e_bppc, e_rbpc} = '0;
  endtask

  task automatic model_step(input stim_t s);
    ment_t f;
    ment_t n;
    bit com, mis, alc;
    int k;
    e_cen = 1'b0; e_cst = 1'b0; e_bpen = 1'b0; e_rb = 1'b0;
    if (!s.rdy) begin
      m_rb = 1'b0;
      return;
    end
    com = (mq.size() > 0) && mq[0].ready;
    mis = com && mq[0].jmp && (mq[0].act != mq[0].pred);
    alc = s.en && !mis && !m_rb && (mq.size() < int'(DEPTH));
    if (com) begin
      f = mq.pop_front();
      if (f.st) begin
        e_cst = 1'b1; e_stid = 5'(f.id);
      end else if (f.rd != 0) begin
        e_cen = 1'b1; e_crd = f.rd; e_cdata = f.val; e_cid = 5'(f.id);
      end
      if (f.jmp) begin
        e_bpen = 1'b1; e_bppc = f.pc; e_bpt = f.act;
      end
      if (mis) begin
        e_rb = 1'b1; e_rbpc = f.rbpc;
      end
    end
    if (s.av) begin
      k = m_find(int'(s.aid));
      if (k >= 0) begin
        mq[k].ready = 1'b1; mq[k].val = s.ares; mq[k].act = s.aj;
      end
    end
    if (s.lv) begin
      k = m_find(int'(s.lid));
      if (k >= 0) begin
        mq[k].ready = 1'b1; mq[k].val = s.lres;
      end
    end
    if (mis) begin
      mq.delete();
      m_next = 1;
    end else if (alc) begin
      n = '{id: m_next, ready: 1'b0, rd: s.rd, jmp: s.jmp, st: s.st, pred: s.pred,
            act: 1'b0, pc: s.pc, rbpc: s.rbpc, val: '0};
      mq.push_back(n);
      m_next = (m_next % int'(DEPTH)) + 1;
    end
    m_rb = mis;
  endtask

  task automatic drive(input stim_t s);
    rdy_in = s.rdy;
    bus.en_signal_from_dispatcher      = s.en;
    bus.rd_from_dispatcher             = s.rd;
    bus.is_jump_from_dispatcher        = s.jmp;
    bus.is_store_from_dispatcher       = s.st;
    bus.predicted_jump_from_dispatcher = s.pred;
    bus.pc_from_dispatcher             = s.pc;
    bus.rollback_pc_from_dispatcher    = s.rbpc;
    bus.Q1_from_dispatcher             = s.q1;
    bus.Q2_from_dispatcher             = s.q2;
    bus.valid_from_alu                 = s.av;
    bus.rob_id_from_alu                = s.aid;
    bus.result_from_alu                = s.ares;
    bus.jump_from_alu                  = s.aj;
    bus.valid_from_lsu                 = s.lv;
    bus.rob_id_from_lsu                = s.lid;
    bus.result_from_lsu                = s.lres;
  endtask

  task automatic check_comb(input stim_t s);
    int k;
    bit r;
    chk("alloc_id", 32'(bus.alloc_id_out), 32'(m_next));
    chk("full", 32'(bus.full_to_fetcher), 32'(mq.size() >= int'(DEPTH) - 2));
    k = m_find(int'(s.q1));
    r = (k >= 0) && mq[k].ready;
    chk("q1_ready", 32'(bus.Q1_ready_to_dispatcher), 32'(r));
    if (r) chk("q1_data", bus.data1_to_dispatcher, mq[k].val);
    k = m_find(int'(s.q2));
    r = (k >= 0) && mq[k].ready;
    chk("q2_ready", 32'(bus.Q2_ready_to_dispatcher), 32'(r));
    if (r) chk("q2_data", bus.data2_to_dispatcher, mq[k].val);
  endtask

  task automatic check_regs();
    chk("commit_en", 32'(bus.commit_en_to_reg), 32'(e_cen && rdy_in));
    chk("commit_rd", 32'(bus.commit_rd_to_reg), 32'(e_crd));
    chk("commit_data", bus.commit_data_to_reg, e_cdata);
    chk("commit_id", 32'(bus.commit_id_to_reg), 32'(e_cid));
    chk("commit_store", 32'(bus.commit_store_to_lsb), 32'(e_cst && rdy_in));
    chk("commit_lsb_id", 32'(bus.commit_id_to_lsb), 32'(e_stid));
    chk("bp_en", 32'(bus.bp_update_en), 32'(e_bpen && rdy_in));
    chk("bp_pc", bus.bp_pc, e_bppc);
    chk("bp_taken", 32'(bus.bp_taken), 32'(e_bpt));
    chk("rollback", 32'(bus.rollback_flag_to_all), 32'(e_rb && rdy_in));
    chk("rollback_pc", bus.rollback_pc_to_fetcher, e_rbpc);
  endtask

  // One clock: drive after the falling edge, check before and after the rising edge
  task automatic tick(input stim_t s);
    drive(s);
    #1;
    check_comb(s);
    @(posedge clk_in);
    model_step(s);
    #1;
    check_regs();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_commit_en", 32'(bus.commit_en_to_reg), 32'(0));
    chk("rst_alloc_id", 32'(bus.alloc_id_out), 32'(1));
    chk("rst_full", 32'(bus.full_to_fetcher), 32'(0));
    rst_in = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int ur[$];
    int k;
    s = idle();
    s.rdy  = ($urandom_range(0, 9) != 0);
    s.en   = ($urandom_range(0, 2) != 0);
    s.rd   = 5'($urandom);
    s.jmp  = ($urandom_range(0, 7) == 0);
    s.st   = !s.jmp && ($urandom_range(0, 3) == 0);
    s.pred = 1'($urandom);
    s.pc   = $urandom;
    s.rbpc = $urandom;
    s.q1   = 5'($urandom_range(0, 18));
    s.q2   = 5'($urandom_range(0, 18));
    foreach (mq[i]) if (!mq[i].ready) ur.push_back(mq[i].id);
    if (ur.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, ur.size() - 1);
      s.av = 1'b1; s.aid = 5'(ur[k]); s.ares = $urandom; s.aj = 1'($urandom);
      ur.delete(k);
    end
    if (ur.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, ur.size() - 1);
      s.lv = 1'b1; s.lid = 5'(ur[k]); s.lres = $urandom;
    end else if (!s.av && $urandom_range(0, 19) == 0) begin
      s.lv = 1'b1; s.lid = 5'($urandom_range(0, 31)); s.lres = $urandom;
    end
    return s;
  endfunction

  initial begin
    vec_t  vt[9];
    stim_t s;
    n_pass  = 0;
    n_total = 0;
    rst_in  = 1'b0;
    drive(idle());
    model_reset();
    repeat (3) @(negedge clk_in);
    #1;
    check_regs();
    check_comb(idle());
    rst_in = 1'b1;

    // In-order commit of out-of-order results; expectations are after each edge
    vt[0] = '{mk_en(1),                2, 1'b0, 5'd0, 32'h0};
    vt[1] = '{mk_en(2),                3, 1'b0, 5'd0, 32'h0};
    vt[2] = '{mk_en(3),                4, 1'b0, 5'd0, 32'h0};
    vt[3] = '{mk_wb(3, 32'h30),        4, 1'b0, 5'd0, 32'h0};
    vt[4] = '{mk_wb(1, 32'h10),        4, 1'b0, 5'd0, 32'h0};
    vt[5] = '{mk_wb(2, 32'h20),        4, 1'b1, 5'd1, 32'h10};
    vt[6] = '{idle(),                  4, 1'b1, 5'd2, 32'h20};
    vt[7] = '{idle(),                  4, 1'b1, 5'd3, 32'h30};
    vt[8] = '{idle(),                  4, 1'b0, 5'd0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      tick(vt[i].s);
      chk("vec_alloc", 32'(bus.alloc_id_out), 32'(vt[i].exp_alloc));
      chk("vec_commit_en", 32'(bus.commit_en_to_reg), 32'(vt[i].exp_cen));
      if (vt[i].exp_cen) begin
        chk("vec_commit_rd", 32'(bus.commit_rd_to_reg), 32'(vt[i].exp_rd));
        chk("vec_commit_data", bus.commit_data_to_reg, vt[i].exp_data);
      end
    end

    // Fill, full threshold, dropped overflow, drain and wrap
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      tick(mk_en((i % 31) + 1));
      chk("fill_full", 32'(bus.full_to_fetcher), 32'(i >= int'(DEPTH) - 3));
    end
    chk("wrap_alloc_id", 32'(bus.alloc_id_out), 32'(1));
    tick(mk_en(9));
    chk("overflow_alloc_id", 32'(bus.alloc_id_out), 32'(1));
    for (int i = 0; i < int'(DEPTH) / 2; i++) begin
      s = mk_wb(2 * i + 1, 32'(100 + i));
      s.lv = 1'b1; s.lid = 5'(2 * i + 2); s.lres = 32'(200 + i);
      tick(s);
    end
    repeat (int'(DEPTH)) tick(idle());
    chk("drained_full", 32'(bus.full_to_fetcher), 32'(0));
    tick(mk_en(4));
    chk("realloc_id", 32'(bus.alloc_id_out), 32'(2));

    // Query forwarding of registered state only
    do_reset();
    for (int i = 1; i <= 6; i++) tick(mk_en(i));
    s = mk_wb(5, 32'hDEAD);
    s.q1 = 5'd5;
    tick(s);
    s = idle(); s.q1 = 5'd5; s.q2 = 5'd6;
    drive(s);
    #1;
    chk("query_q1_ready", 32'(bus.Q1_ready_to_dispatcher), 32'(1));
    chk("query_q1_data", bus.data1_to_dispatcher, 32'hDEAD);
    chk("query_q2_ready", 32'(bus.Q2_ready_to_dispatcher), 32'(0));
    s.q1 = 5'd0;
    drive(s);
    #1;
    chk("query_q0_ready", 32'(bus.Q1_ready_to_dispatcher), 32'(0));
    tick(s);

    // Mispredicted jump with younger entries
    do_reset();
    s = mk_en(1);
    s.jmp = 1'b1; s.pred = 1'b0; s.pc = 32'h100; s.rbpc = 32'h200;
    tick(s);
    for (int i = 2; i <= 5; i++) tick(mk_en(i));
    s = mk_wb(1, 32'h104);
    s.aj = 1'b1;
    tick(s);
    tick(idle());
    chk("mis_rollback", 32'(bus.rollback_flag_to_all), 32'(1));
    chk("mis_rollback_pc", bus.rollback_pc_to_fetcher, 32'h200);
    chk("mis_bp_en", 32'(bus.bp_update_en), 32'(1));
    chk("mis_bp_taken", 32'(bus.bp_taken), 32'(1));
    chk("mis_bp_pc", bus.bp_pc, 32'h100);
    chk("mis_alloc_id", 32'(bus.alloc_id_out), 32'(1));
    tick(mk_en(7));
    chk("post_rb_flag", 32'(bus.rollback_flag_to_all), 32'(0));
    chk("pulse_alloc_ignored", 32'(bus.alloc_id_out), 32'(1));
    tick(mk_en(8));
    chk("post_rb_alloc", 32'(bus.alloc_id_out), 32'(2));

    // Store commit and rd=0 commit
    do_reset();
    s = mk_en(7);
    s.st = 1'b1;
    tick(s);
    tick(mk_en(0));
    s = idle(); s.lv = 1'b1; s.lid = 5'd1; s.lres = 32'h55;
    tick(s);
    tick(mk_wb(2, 32'h66));
    chk("store_commit", 32'(bus.commit_store_to_lsb), 32'(1));
    chk("store_lsb_id", 32'(bus.commit_id_to_lsb), 32'(1));
    chk("store_no_reg", 32'(bus.commit_en_to_reg), 32'(0));
    tick(idle());
    chk("rd0_no_reg", 32'(bus.commit_en_to_reg), 32'(0));
    chk("rd0_no_store", 32'(bus.commit_store_to_lsb), 32'(0));

    // Stall masking and hold, then asynchronous reset with live entries
    do_reset();
    for (int i = 1; i <= 8; i++) tick(mk_en(i));
    s = mk_wb(1, 32'h11);
    s.lv = 1'b1; s.lid = 5'd2; s.lres = 32'h22;
    tick(s);
    tick(idle());
    tick(idle());
    rdy_in = 1'b0;
    #1;
    chk("stall_mask_cen", 32'(bus.commit_en_to_reg), 32'(0));
    chk("stall_hold_rd", 32'(bus.commit_rd_to_reg), 32'(2));
    chk("stall_hold_data", bus.commit_data_to_reg, 32'h22);
    s = mk_wb(3, 32'h33);
    s.rdy = 1'b0;
    tick(s);
    s = idle(); s.rdy = 1'b0;
    tick(s);
    tick(s);
    chk("stall_no_commit", 32'(bus.commit_en_to_reg), 32'(0));
    tick(mk_wb(3, 32'h33));
    tick(idle());
    chk("resume_commit_en", 32'(bus.commit_en_to_reg), 32'(1));
    chk("resume_commit_rd", 32'(bus.commit_rd_to_reg), 32'(3));
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) tick(rand_stim());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
